// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
// SPI slave bundle: serial pins plus the parallel word/strobe side.
// Defining SPI_SLAVE_FRAME_ERR_EN adds the frame_err strobe.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_send;
    logic                  sclk;
    logic                  csn;
    logic                  mosi;
    logic                  miso;
    logic                  spi_done;
    logic [DATA_WIDTH-1:0] data_recv;
    logic                  busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  frame_err;
`endif

    modport slave (
        input  data_send, sclk, csn, mosi,
`ifdef SPI_SLAVE_FRAME_ERR_EN
        output frame_err,
`endif
        output miso, spi_done, data_recv, busy
    );

    modport master (
        output data_send, sclk, csn, mosi,
`ifdef SPI_SLAVE_FRAME_ERR_EN
        input  frame_err,
`endif
        input  miso, spi_done, data_recv, busy
    );
endinterface

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI responder: synchronizes sclk/csn/mosi into clk, full-duplex MSB-first words.
// Optional truncated-word strobe frame_err under `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 1
) (
    input  logic       clk,
    input  logic       arst,
    spi_slave_if.slave bus
);
    localparam int            MSB       = DATA_WIDTH - 1;
    localparam int            CW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST      = CW'(DATA_WIDTH - 1);
    localparam logic          SCLK_IDLE = (CPOL != 0);
    localparam logic          PHASE1    = (CPHA != 0);
    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_XFER   = 1'b1;

    logic                  csn_s1_q;
    logic                  csn_s2_q;
    logic                  csn_d1_q;
    logic                  sclk_s1_q;
    logic                  sclk_s2_q;
    logic                  sclk_d1_q;
    logic                  mosi_s1_q;
    logic                  mosi_s2_q;
    logic [1:0]            sync_vld_q;
    logic                  armed_q;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [CW-1:0]         bit_cnt_q;
    logic [CW-1:0]         bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sr_q;
    logic [DATA_WIDTH-1:0] rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q;
    logic [DATA_WIDTH-1:0] tx_sr_d;
    logic                  miso_q;
    logic                  miso_d;
    logic                  spi_done_q;
    logic                  spi_done_d;
    logic [DATA_WIDTH-1:0] data_recv_q;
    logic [DATA_WIDTH-1:0] data_recv_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  frame_err_q;
    logic                  frame_err_d;
`endif

    logic sclk_edge;
    logic sclk_lead;
    logic sclk_trail;
    logic sample_edge;
    logic shift_edge;
    logic csn_fall;
    logic csn_rise;

    // The sync flops reset to idle levels, so the edge detector would see a
    // phantom csn fall after reset; armed_q blocks that until csn is seen high.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            csn_s1_q   <= 1'b1;
            csn_s2_q   <= 1'b1;
            csn_d1_q   <= 1'b1;
            sclk_s1_q  <= SCLK_IDLE;
            sclk_s2_q  <= SCLK_IDLE;
            sclk_d1_q  <= SCLK_IDLE;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            sync_vld_q <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            csn_s1_q   <= bus.csn;
            csn_s2_q   <= csn_s1_q;
            csn_d1_q   <= csn_s2_q;
            sclk_s1_q  <= bus.sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_d1_q  <= sclk_s2_q;
            mosi_s1_q  <= bus.mosi;
            mosi_s2_q  <= mosi_s1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            armed_q    <= armed_q | (sync_vld_q[1] & csn_s2_q);
        end
    end

    assign sclk_edge   = (sclk_s2_q != sclk_d1_q);
    assign sclk_lead   = sclk_edge & (sclk_s2_q != SCLK_IDLE);
    assign sclk_trail  = sclk_edge & (sclk_s2_q == SCLK_IDLE);
    assign sample_edge = PHASE1 ? sclk_trail : sclk_lead;
    assign shift_edge  = PHASE1 ? sclk_lead : sclk_trail;
    assign csn_fall    = armed_q & csn_d1_q & ~csn_s2_q;
    assign csn_rise    = ~csn_d1_q & csn_s2_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        spi_done_d  = 1'b0;
        data_recv_d = data_recv_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (csn_fall) begin
                    state_d   = ST_XFER;
                    tx_sr_d   = bus.data_send;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    if (!PHASE1) begin
                        miso_d = bus.data_send[MSB];
                    end
                end
            end
            default: begin
                // Reload in the cycle spi_done is visible, so a data_send
                // written in response to the strobe goes out as the next word.
                if (spi_done_q) begin
                    tx_sr_d = bus.data_send;
                end
                if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s2_q};
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d   = '0;
                        spi_done_d  = 1'b1;
                        data_recv_d = rx_sr_d;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                if (shift_edge) begin
                    if (PHASE1) begin
                        miso_d  = tx_sr_q[MSB];
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end else if (bit_cnt_q == '0) begin
                        miso_d = tx_sr_q[MSB];
                    end else begin
                        miso_d  = tx_sr_q[DATA_WIDTH-2];
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                if (csn_rise) begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = (bit_cnt_d != '0);
`endif
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            miso_q      <= 1'b0;
            spi_done_q  <= 1'b0;
            data_recv_q <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            spi_done_q  <= spi_done_d;
            data_recv_q <= data_recv_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign bus.miso      = miso_q;
    assign bus.spi_done  = spi_done_q;
    assign bus.data_recv = data_recv_q;
    assign bus.busy      = (state_q == ST_XFER);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign bus.frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Bench for spi_slave: one instance per CPOL/CPHA mode, a bench-side SPI master
// per instance, and a per-mode scoreboard of expected received words.
module tb_spi_slave;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst;
    logic [3:0]   sclk_v;
    logic [3:0]   csn_v;
    logic [3:0]   mosi_v;
    logic [W-1:0] ds_v [4];
    logic [3:0]   miso_v;
    logic [3:0]   done_v;
    logic [3:0]   busy_v;
    logic [3:0]   ferr_v;
    logic [W-1:0] recv_v [4];

    logic [W-1:0] exp_q [4][$];
    int           done_cnt [4] = '{0, 0, 0, 0};
    int           ferr_cnt [4] = '{0, 0, 0, 0};
    int           checks = 0;
    int           failures = 0;
    logic [3:0]   ds_arm;
    logic [W-1:0] ds_new [4];

    always #10 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_if #(.DATA_WIDTH(W)) bus ();
        assign bus.sclk      = sclk_v[g];
        assign bus.csn       = csn_v[g];
        assign bus.mosi      = mosi_v[g];
        assign bus.data_send = ds_v[g];
        assign miso_v[g]     = bus.miso;
        assign done_v[g]     = bus.spi_done;
        assign busy_v[g]     = bus.busy;
        assign recv_v[g]     = bus.data_recv;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        assign ferr_v[g]     = bus.frame_err;
`else
        assign ferr_v[g]     = 1'b0;
`endif
        spi_slave #(.DATA_WIDTH(W), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk  (clk),
            .arst (arst),
            .bus  (bus)
        );
    end

    // Scoreboard monitor: every spi_done must match the oldest expected word.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (ferr_v[m]) ferr_cnt[m]++;
            if (done_v[m]) begin
                logic [W-1:0] e;
                done_cnt[m]++;
                checks++;
                if (exp_q[m].size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious_done_m%0d data_recv=0x%02h expected no strobe", m, recv_v[m]);
                end else begin
                    e = exp_q[m].pop_front();
                    if (recv_v[m] !== e) begin
                        failures++;
                        $display("FAIL sb_data_recv_m%0d actual=0x%02h expected=0x%02h", m, recv_v[m], e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    task automatic wait_half(input int m, input int n);
        repeat (n) begin
            @(negedge clk);
            if (ds_arm[m] && done_v[m]) begin
                ds_v[m]   = ds_new[m];
                ds_arm[m] = 1'b0;
            end
        end
    endtask

    // Master side: n bits MSB first; returns the word seen on miso.
    task automatic xfer(input int m, input int n, input logic [W-1:0] tx, input int half,
                        output logic [W-1:0] rx);
        logic cpol;
        logic cpha;
        cpol = m[1];
        cpha = m[0];
        rx   = '0;
        if (!cpha) mosi_v[m] = tx[7];
        for (int i = 0; i < n; i++) begin
            wait_half(m, half);
            sclk_v[m] = ~cpol;
            if (cpha) mosi_v[m] = tx[7-i];
            else rx = {rx[6:0], miso_v[m]};
            wait_half(m, half);
            sclk_v[m] = cpol;
            if (cpha) rx = {rx[6:0], miso_v[m]};
            else if (i < 7) mosi_v[m] = tx[6-i];
        end
    endtask

    task automatic cs_high(input int m, input int half);
        wait_half(m, half);
        csn_v[m] = 1'b1;
        wait_half(m, 2 * half);
    endtask

    initial begin : main
        logic [W-1:0] rx;
        logic [W-1:0] rx2;
        int           d0;
        int           f0;

        arst   = 1'b1;
        sclk_v = 4'b1100;
        csn_v  = 4'hF;
        mosi_v = 4'h0;
        ds_arm = 4'h0;
        for (int m = 0; m < 4; m++) begin
            ds_v[m]   = '0;
            ds_new[m] = '0;
        end

        repeat (2) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("reset_recv_m%0d", m), recv_v[m], 8'h00);
                chk($sformatf("reset_flags_m%0d", m), {5'b0, miso_v[m], done_v[m], busy_v[m]}, 8'h00);
            end
        end
        arst = 1'b0;
        repeat (10) @(negedge clk);

        // Mode 1 (CPOL=0, CPHA=1) at 100 kHz sclk
        ds_v[1] = 8'h3C;
        d0 = done_cnt[1];
        exp_q[1].push_back(8'hA5);
        csn_v[1] = 1'b0;
        xfer(1, 8, 8'hA5, 250, rx);
        cs_high(1, 250);
        chk("m1_100k_master_rx", rx, 8'h3C);
        chk("m1_100k_done_count", 8'(done_cnt[1] - d0), 8'd1);

        for (int m = 0; m < 4; m++) begin
            ds_v[m] = 8'h5A;
            d0 = done_cnt[m];
            exp_q[m].push_back(8'h9A);
            csn_v[m] = 1'b0;
            xfer(m, 8, 8'h9A, 10, rx);
            cs_high(m, 10);
            chk($sformatf("mode%0d_master_rx", m), rx, 8'h5A);
            chk($sformatf("mode%0d_done_count", m), 8'(done_cnt[m] - d0), 8'd1);
        end

        // Back-to-back words; data_send is swapped when the first strobe appears
        for (int m = 0; m < 4; m++) begin
            ds_v[m]   = 8'h66;
            ds_new[m] = 8'hC3;
            ds_arm[m] = 1'b1;
            d0 = done_cnt[m];
            exp_q[m].push_back(8'h12);
            exp_q[m].push_back(8'h34);
            csn_v[m] = 1'b0;
            xfer(m, 8, 8'h12, 10, rx);
            xfer(m, 8, 8'h34, 10, rx2);
            cs_high(m, 10);
            chk($sformatf("b2b_m%0d_rx_word1", m), rx, 8'h66);
            chk($sformatf("b2b_m%0d_rx_word2", m), rx2, 8'hC3);
            chk($sformatf("b2b_m%0d_done_count", m), 8'(done_cnt[m] - d0), 8'd2);
        end

        // Truncated word: 5 bits, then csn released
        for (int m = 0; m < 4; m++) begin
            d0 = done_cnt[m];
            f0 = ferr_cnt[m];
            csn_v[m] = 1'b0;
            xfer(m, 5, 8'hF0, 10, rx);
            cs_high(m, 10);
            chk($sformatf("trunc_m%0d_recv_held", m), recv_v[m], 8'h34);
            chk($sformatf("trunc_m%0d_no_done", m), 8'(done_cnt[m] - d0), 8'd0);
            chk($sformatf("trunc_m%0d_busy_low", m), {7'b0, busy_v[m]}, 8'h00);
`ifdef SPI_SLAVE_FRAME_ERR_EN
            chk($sformatf("trunc_m%0d_frame_err", m), 8'(ferr_cnt[m] - f0), 8'd1);
`else
            chk($sformatf("trunc_m%0d_frame_err_absent", m), 8'(ferr_cnt[m] - f0), 8'd0);
`endif
        end

        // Reset in the middle of a frame, the rest of that frame ignored, then a fresh frame
        d0 = done_cnt[1];
        csn_v[1] = 1'b0;
        xfer(1, 3, 8'hB6, 10, rx);
        wait_half(1, 5);
        arst = 1'b1;
        wait_half(1, 2);
        chk("arst_mid_recv", recv_v[1], 8'h00);
        chk("arst_mid_flags", {5'b0, miso_v[1], done_v[1], busy_v[1]}, 8'h00);
        arst = 1'b0;
        xfer(1, 5, 8'hB6, 10, rx);
        cs_high(1, 10);
        chk("arst_no_rejoin_done", 8'(done_cnt[1] - d0), 8'd0);
        chk("arst_no_rejoin_recv", recv_v[1], 8'h00);

        ds_v[1] = 8'h42;
        d0 = done_cnt[1];
        exp_q[1].push_back(8'h81);
        csn_v[1] = 1'b0;
        xfer(1, 8, 8'h81, 10, rx);
        cs_high(1, 10);
        chk("post_arst_master_rx", rx, 8'h42);
        chk("post_arst_done_count", 8'(done_cnt[1] - d0), 8'd1);
        chk("post_arst_recv", recv_v[1], 8'h81);

        for (int m = 0; m < 4; m++) begin
            chk($sformatf("sb_drained_m%0d", m), 8'(exp_q[m].size()), 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (responder) for the far end of the link driven by spi_master; full-duplex, one word of DATA_WIDTH bits per frame, back-to-back words allowed within one csn assertion.
- sclk, csn and mosi are asynchronous to clk; each passes through a 2-flop synchronizer, then edge detection runs in the clk domain.
- Returns data_send on miso and presents the captured mosi word on data_recv with a one-cycle spi_done strobe.
- Used on-chip as the peripheral-side endpoint and as the loopback partner for spi_master benches.

Parameters:
DATA_WIDTH, 8, bits per word; MSB first.
CPOL, 0, sclk idle level. 0: idle low; 1: idle high.
CPHA, 1, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge.

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency.
arst  input  1  asynchronous reset, active-high.
data_send  input  DATA_WIDTH  word to return; latched at frame start and at every word boundary.
sclk  input  1  SPI clock from master.
csn  input  1  chip select, active-low.
mosi  input  1  master-out serial data.
miso  output  1  slave-out serial data.
spi_done  output  1  one-cycle pulse; data_recv is valid in the same cycle.
data_recv  output  DATA_WIDTH  last complete received word; held until the next word completes.
busy  output  1  high while the synchronized csn is low.

Behaviour:
- Reset values: miso=0, spi_done=0, data_recv=0, busy=0, FSM=IDLE, bit_cnt=0, shift registers=0. All synchronizer flops reset to their idle values: csn=1, sclk=CPOL.
- Edge definitions, on the synchronized sclk:
  - leading edge = transition away from CPOL.
  - trailing edge = transition back to CPOL.
- FSM states:
  - IDLE: on the falling edge of synchronized csn, latch tx_sr<=data_send, clear bit_cnt and rx_sr, go to XFER.
    - CPHA=0: miso<=data_send[MSB] in that same cycle.
  - XFER: handles sample and shift edges (rules below).
- Sample edge (CPHA=0 leading, CPHA=1 trailing):
  - rx_sr<={rx_sr[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH-1 on a sample edge: next cycle data_recv<=completed word, spi_done=1 for one clk, bit_cnt<=0, tx_sr<=data_send (reload for the next word).
- Shift edge (CPHA=0 trailing, CPHA=1 leading):
  - miso<=next tx bit, MSB first.
  - CPHA=1: the first leading edge of each word drives tx_sr[MSB].
  - CPHA=0: after the last trailing edge of a word, drive the MSB of the reloaded word.
- Latency: mosi-to-capture is 3 clk after the raw sclk edge (2 synchronizer + 1 edge detect). miso update is 3 clk after the raw shift edge.
- csn rising (synchronized) in XFER: go to IDLE next cycle and drop busy.
  - A partial word (bit_cnt!=0) is discarded: no spi_done, data_recv unchanged.
  - A complete word whose spi_done coincides with csn rising still pulses spi_done.
- sclk edges while csn is high are ignored. miso is held at 0 in IDLE.
- arst asserted mid-frame: all state returns to reset values immediately. Once arst releases, the FSM waits for the next csn falling edge; a frame already in progress is not rejoined.

Optional Feature:
SPI_SLAVE_FRAME_ERR_EN
- Defined: adds output frame_err (1 bit, reset 0). frame_err pulses for one clk when csn rises with 0 < bit_cnt < DATA_WIDTH, i.e. a truncated word.
- Not defined: the port is absent and truncated words are silently discarded. All other behaviour is identical.

Test Plan:
- Reset: arst high for 40 ns -> miso=0, spi_done=0, data_recv=0x00, busy=0 throughout reset.
- CPOL=0, CPHA=1, 100 kHz sclk, 50 MHz clk, spi_master sends 0xA5 while data_send=0x3C -> master data_recv=0x3C, slave data_recv=0xA5, exactly one spi_done pulse.
- All four CPOL/CPHA combinations, mosi word 0x9A, data_send 0x5A -> both sides receive correctly in every mode; miso is stable at every master sample edge.
- Two back-to-back words in one csn assertion, 0x12 then 0x34, with data_send changed to 0xC3 after the first spi_done -> two spi_done pulses; data_recv=0x12 then 0x34; second miso word is 0xC3.
- csn raised after 5 bits -> no spi_done; data_recv keeps its previous value; with SPI_SLAVE_FRAME_ERR_EN, one frame_err pulse.
- arst pulsed after bit 3 of a frame, then a fresh frame sending 0x81 -> slave data_recv=0x81; no spurious spi_done.
